// File: rtl/hbuf_wvb_loader_pkg.sv
// hbuf_pkg: constants and FSM encoding shared by the waveform-buffer to hit-buffer loader.
package hbuf_pkg;

  localparam int HBUF_RDOUT_DEPTH = 1024;
  localparam int HBUF_RDOUT_AW    = 10;
  localparam int HBUF_LEN_W       = 11;
  localparam int HBUF_DPRAM_LEN_W = 16;
  localparam int HBUF_WORD_W      = 32;

  localparam logic [HBUF_LEN_W-1:0] HBUF_MAX_LEN = HBUF_LEN_W'(HBUF_RDOUT_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_DISCARD,
    S_PAD,
    S_RUN,
    S_WAIT_HI,
    S_WAIT_LO
  } hbuf_state_e;

endpackage

// File: rtl/hbuf_wvb_loader_if.sv
// Bundles the two readout FIFOs and the hit-buffer DPRAM/handover port of the loader.
interface hbuf_wvb_loader_if;
  import hbuf_pkg::*;

  logic                        hdr_empty;
  logic [HBUF_LEN_W-1:0]       hdr_len;
  logic                        hdr_rdreq;
  logic                        data_empty;
  logic [HBUF_WORD_W-1:0]      data_dout;
  logic                        data_rdreq;
  logic [HBUF_DPRAM_LEN_W-1:0] dpram_len_out;
  logic                        rdout_dpram_run;
  logic                        dpram_busy;
  logic                        rdout_dpram_wren;
  logic [HBUF_RDOUT_AW-1:0]    rdout_dpram_wr_addr;
  logic [HBUF_WORD_W-1:0]      rdout_dpram_data;

  modport master (
    input  hdr_empty, hdr_len, data_empty, data_dout, dpram_busy,
    output hdr_rdreq, data_rdreq, dpram_len_out, rdout_dpram_run,
           rdout_dpram_wren, rdout_dpram_wr_addr, rdout_dpram_data
  );

  modport slave (
    output hdr_empty, hdr_len, data_empty, data_dout, dpram_busy,
    input  hdr_rdreq, data_rdreq, dpram_len_out, rdout_dpram_run,
           rdout_dpram_wren, rdout_dpram_wr_addr, rdout_dpram_data
  );

endinterface

// File: rtl/hbuf_wvb_loader.sv
// Copies one waveform packet at a time from the readout FIFOs into the hit-buffer DPRAM.
// Define HBUF_LOADER_PAD_EN to pad odd-length packets with one zero word.
module hbuf_wvb_loader
  import hbuf_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  hbuf_wvb_loader_if.master      bus,
  output logic [31:0]            pkt_cnt,
  output logic                   len_err
);

  hbuf_state_e                 state_q, state_d;
  logic [HBUF_LEN_W-1:0]       len_q, len_d;
  logic [HBUF_LEN_W-1:0]       wcnt_q, wcnt_d;
  logic [31:0]                 pkt_cnt_q, pkt_cnt_d;
  logic                        wren_q, wren_d;
  logic [HBUF_RDOUT_AW-1:0]    addr_q, addr_d;
  logic [HBUF_WORD_W-1:0]      data_q, data_d;
  logic                        run_q, run_d;
  logic [HBUF_DPRAM_LEN_W-1:0] len_out_q, len_out_d;
  logic                        len_err_q, len_err_d;
  logic                        hdr_rdreq_c, data_rdreq_c;
  logic [HBUF_LEN_W-1:0]       eff_len;

`ifdef HBUF_LOADER_PAD_EN
  assign eff_len = len_q + {{(HBUF_LEN_W-1){1'b0}}, len_q[0]};
`else
  assign eff_len = len_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      len_q     <= '0;
      wcnt_q    <= '0;
      pkt_cnt_q <= '0;
      wren_q    <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      run_q     <= 1'b0;
      len_out_q <= '0;
      len_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      wcnt_q    <= wcnt_d;
      pkt_cnt_q <= pkt_cnt_d;
      wren_q    <= wren_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      run_q     <= run_d;
      len_out_q <= len_out_d;
      len_err_q <= len_err_d;
    end
  end

  // FIFO pops are decided combinationally so they never fire on an empty FIFO;
  // everything reaching the DPRAM and controller is registered one cycle later.
  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    wcnt_d       = wcnt_q;
    pkt_cnt_d    = pkt_cnt_q;
    wren_d       = 1'b0;
    addr_d       = '0;
    data_d       = '0;
    run_d        = 1'b0;
    len_out_d    = '0;
    len_err_d    = 1'b0;
    hdr_rdreq_c  = 1'b0;
    data_rdreq_c = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (en && !bus.hdr_empty && !bus.dpram_busy) begin
          hdr_rdreq_c = 1'b1;
          len_d       = bus.hdr_len;
          wcnt_d      = '0;
          if (bus.hdr_len == '0) begin
            len_err_d = 1'b1;
          end else if (bus.hdr_len > HBUF_MAX_LEN) begin
            len_err_d = 1'b1;
            state_d   = S_DISCARD;
          end else begin
            state_d   = S_LOAD;
          end
        end
      end

      S_LOAD: begin
        if (!bus.data_empty) begin
          data_rdreq_c = 1'b1;
          wren_d       = 1'b1;
          addr_d       = wcnt_q[HBUF_RDOUT_AW-1:0];
          data_d       = bus.data_dout;
          wcnt_d       = wcnt_q + 1'b1;
          if (wcnt_q == len_q - 1'b1) begin
`ifdef HBUF_LOADER_PAD_EN
            state_d = len_q[0] ? S_PAD : S_RUN;
`else
            state_d = S_RUN;
`endif
          end
        end
      end

      // Oversized packets are drained word for word to keep the FIFOs framed.
      S_DISCARD: begin
        if (!bus.data_empty) begin
          data_rdreq_c = 1'b1;
          wcnt_d       = wcnt_q + 1'b1;
          if (wcnt_q == len_q - 1'b1) begin
            state_d = S_IDLE;
          end
        end
      end

`ifdef HBUF_LOADER_PAD_EN
      S_PAD: begin
        wren_d  = 1'b1;
        addr_d  = len_q[HBUF_RDOUT_AW-1:0];
        data_d  = '0;
        state_d = S_RUN;
      end
`endif

      S_RUN: begin
        run_d     = 1'b1;
        len_out_d = {{(HBUF_DPRAM_LEN_W-HBUF_LEN_W){1'b0}}, eff_len};
        state_d   = S_WAIT_HI;
      end

      S_WAIT_HI: begin
        if (bus.dpram_busy) begin
          state_d = S_WAIT_LO;
        end
      end

      S_WAIT_LO: begin
        if (!bus.dpram_busy) begin
          pkt_cnt_d = pkt_cnt_q + 32'd1;
          state_d   = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign bus.hdr_rdreq           = hdr_rdreq_c & rst_n;
  assign bus.data_rdreq          = data_rdreq_c & rst_n;
  assign bus.rdout_dpram_wren    = wren_q;
  assign bus.rdout_dpram_wr_addr = addr_q;
  assign bus.rdout_dpram_data    = data_q;
  assign bus.rdout_dpram_run     = run_q;
  assign bus.dpram_len_out       = len_out_q;
  assign pkt_cnt                 = pkt_cnt_q;
  assign len_err                 = len_err_q;

endmodule

// File: tb/tb_hbuf_wvb_loader.sv
// Scoreboard bench for hbuf_wvb_loader with FWFT FIFO and hit-buffer controller models.
// Expected padding follows HBUF_LOADER_PAD_EN the same way as the design build.
module tb_hbuf_wvb_loader;
  import hbuf_pkg::*;

  localparam int EV_WRITE = 1;
  localparam int EV_RUN   = 2;
  localparam int EV_ERR   = 3;

  typedef struct {
    int          kind;
    logic [31:0] a;
    logic [31:0] d;
    int          off;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic [31:0] pkt_cnt;
  logic        len_err;

  hbuf_wvb_loader_if bus();

  hbuf_wvb_loader dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .bus     (bus),
    .pkt_cnt (pkt_cnt),
    .len_err (len_err)
  );

  logic [HBUF_LEN_W-1:0] hq[$];
  logic [31:0]           dq[$];
  exp_t                  sb[$];

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int accept_cyc = 0;
  int n_accept = 0;
  int n_writes = 0;
  int data_pops = 0;
  int busy_len = 3;
  int exp_pkt = 0;
  bit stall_toggle = 0;
  bit phase = 0;
  bit outstanding = 0;
  bit seen_busy = 0;
  bit prev_pop = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic timeoutFail(input string name, input int budget);
    n_vec++;
    n_err++;
    $display("[TB] FAIL %s: no progress within %0d cycles", name, budget);
  endtask

  task automatic pushPacket(input int len, input logic [31:0] base);
    for (int i = 0; i < len; i++) dq.push_back(base + 32'(i));
    hq.push_back(HBUF_LEN_W'(len));
  endtask

  task automatic expectPacket(input int len, input logic [31:0] base, input bit timed);
    exp_t e;
    int   eff;
    int   run_off;
    if (len == 0 || len > HBUF_RDOUT_DEPTH) begin
      e = '{kind: EV_ERR, a: 32'd0, d: 32'd0, off: timed ? 1 : -1};
      sb.push_back(e);
      return;
    end
    for (int i = 0; i < len; i++) begin
      e = '{kind: EV_WRITE, a: 32'(i), d: base + 32'(i), off: timed ? i + 2 : -1};
      sb.push_back(e);
    end
    eff     = len;
    run_off = len + 2;
`ifdef HBUF_LOADER_PAD_EN
    if (len % 2 == 1) begin
      e = '{kind: EV_WRITE, a: 32'(len), d: 32'd0, off: timed ? len + 2 : -1};
      sb.push_back(e);
      eff     = len + 1;
      run_off = len + 3;
    end
`endif
    e = '{kind: EV_RUN, a: 32'(eff), d: 32'd0, off: timed ? run_off : -1};
    sb.push_back(e);
  endtask

  task automatic applyStimulus(input int len, input logic [31:0] base, input bit timed);
    pushPacket(len, base);
    expectPacket(len, base, timed);
  endtask

  task automatic checkEvent(input int kind, input logic [31:0] a, input logic [31:0] d);
    exp_t e;
    n_vec++;
    if (sb.size() == 0) begin
      n_err++;
      $display("[TB] FAIL unexpected_event: kind=%0d a=%0h d=%0h, expected nothing", kind, a, d);
      return;
    end
    e = sb.pop_front();
    if (e.kind != kind || e.a !== a || e.d !== d || (e.off >= 0 && cyc - accept_cyc != e.off)) begin
      n_err++;
      $display("[TB] FAIL event: got kind=%0d a=%0h d=%0h at +%0d, expected kind=%0d a=%0h d=%0h at +%0d",
               kind, a, d, cyc - accept_cyc, e.kind, e.a, e.d, e.off);
    end
  endtask

  // FWFT FIFO model: pops on the edge where rdreq was seen, presents the new head just after.
  initial begin
    bus.hdr_empty  = 1'b1;
    bus.hdr_len    = '0;
    bus.data_empty = 1'b1;
    bus.data_dout  = '0;
    forever begin
      @(posedge clk);
      if (bus.hdr_rdreq && hq.size() > 0) void'(hq.pop_front());
      if (bus.data_rdreq && dq.size() > 0) begin
        void'(dq.pop_front());
        data_pops++;
      end
      #1;
      phase          = ~phase;
      bus.hdr_empty  = (hq.size() == 0);
      bus.hdr_len    = (hq.size() > 0) ? hq[0] : '0;
      bus.data_empty = (dq.size() == 0) || (stall_toggle && phase);
      bus.data_dout  = (dq.size() > 0) ? dq[0] : '0;
    end
  end

  // Hit-buffer controller model: busy rises the cycle after run and stays up busy_len cycles.
  initial begin
    bus.dpram_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n && bus.rdout_dpram_run) begin
        @(posedge clk);
        #1 bus.dpram_busy = 1'b1;
        repeat (busy_len) @(posedge clk);
        #1 bus.dpram_busy = 1'b0;
      end
    end
  end

  // Monitor: every DPRAM write, run strobe and length error is matched against the scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        prev_pop    = 1'b0;
        outstanding = 1'b0;
        seen_busy   = 1'b0;
        continue;
      end
      if (bus.rdout_dpram_wren) begin
        n_writes++;
        checkOutput("wren_after_pop", 32'(prev_pop), 32'd1);
        checkEvent(EV_WRITE, 32'(bus.rdout_dpram_wr_addr), bus.rdout_dpram_data);
      end
      if (bus.rdout_dpram_run) begin
        checkEvent(EV_RUN, 32'(bus.dpram_len_out), 32'd0);
        outstanding = 1'b1;
        seen_busy   = 1'b0;
      end
      if (len_err) checkEvent(EV_ERR, 32'd0, 32'd0);
      if (bus.hdr_rdreq) begin
        checkOutput("hdr_rdreq_nonempty", 32'(bus.hdr_empty), 32'd0);
        checkOutput("hdr_rdreq_after_busy", 32'(outstanding), 32'd0);
        accept_cyc = cyc;
        n_accept++;
      end
      if (bus.data_rdreq) checkOutput("data_rdreq_nonempty", 32'(bus.data_empty), 32'd0);
      if (outstanding && bus.dpram_busy) seen_busy = 1'b1;
      if (outstanding && seen_busy && !bus.dpram_busy) outstanding = 1'b0;
      prev_pop = bus.data_rdreq;
    end
  end

  task automatic waitDrain(input int budget);
    int k = 0;
    while (!(sb.size() == 0 && !outstanding && !bus.dpram_busy)) begin
      @(posedge clk);
      k++;
      if (k > budget) begin
        timeoutFail("drain", budget);
        return;
      end
    end
    repeat (4) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic waitEvent(input int sel, input int target, input int budget);
    int k = 0;
    forever begin
      if (sel == 0 && n_accept >= target) return;
      if (sel == 1 && n_writes >= target) return;
      if (sel == 2 && dq.size() == 0) return;
      @(posedge clk);
      k++;
      if (k > budget) begin
        timeoutFail("wait_event", budget);
        return;
      end
    end
  endtask

  initial begin
    int pops0;
    int acc0;
    rst_n = 1'b0;
    en    = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    checkOutput("rst_wren", 32'(bus.rdout_dpram_wren), 32'd0);
    checkOutput("rst_run", 32'(bus.rdout_dpram_run), 32'd0);
    checkOutput("rst_pkt_cnt", pkt_cnt, 32'd0);
    checkOutput("rst_len_err", 32'(len_err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    en    = 1'b1;

    $display("[TB] len=4 no stalls");
    applyStimulus(4, 32'h0000_00A0, 1'b1);
    waitDrain(200);
    exp_pkt = 1;
    checkOutput("pkt_cnt_len4", pkt_cnt, 32'(exp_pkt));

    $display("[TB] len=5 with toggling data_empty");
    stall_toggle = 1'b1;
    applyStimulus(5, 32'h0000_00B0, 1'b0);
    waitDrain(200);
    stall_toggle = 1'b0;
    exp_pkt = 2;
    checkOutput("pkt_cnt_len5", pkt_cnt, 32'(exp_pkt));

    $display("[TB] len=0 then len=2");
    applyStimulus(0, 32'h0, 1'b1);
    applyStimulus(2, 32'h0000_00C0, 1'b0);
    waitDrain(200);
    exp_pkt = 3;
    checkOutput("pkt_cnt_len0_len2", pkt_cnt, 32'(exp_pkt));

    $display("[TB] len=1500 discard");
    pops0 = data_pops;
    applyStimulus(1500, 32'h0000_D000, 1'b1);
    waitEvent(2, 0, 4000);
    waitDrain(100);
    checkOutput("discard_pops", 32'(data_pops - pops0), 32'd1500);
    checkOutput("pkt_cnt_discard", pkt_cnt, 32'(exp_pkt));
    applyStimulus(2, 32'h0000_00E0, 1'b1);
    waitDrain(200);
    exp_pkt = 4;
    checkOutput("pkt_cnt_after_discard", pkt_cnt, 32'(exp_pkt));

    $display("[TB] two queued packets, busy held 100 cycles");
    busy_len = 100;
    applyStimulus(2, 32'h0000_00F0, 1'b0);
    applyStimulus(3, 32'h0000_00F8, 1'b0);
    waitDrain(1000);
    busy_len = 3;
    exp_pkt = 6;
    checkOutput("pkt_cnt_busy_hold", pkt_cnt, 32'(exp_pkt));

    $display("[TB] en dropped mid-packet");
    acc0 = n_accept;
    applyStimulus(3, 32'h0000_0100, 1'b0);
    waitEvent(0, acc0 + 1, 200);
    #1 en = 1'b0;
    pushPacket(3, 32'h0000_0200);
    waitDrain(200);
    repeat (20) @(posedge clk);
    #1;
    exp_pkt = 7;
    checkOutput("pkt_cnt_en_low", pkt_cnt, 32'(exp_pkt));
    checkOutput("hdr_held_en_low", 32'(hq.size()), 32'd1);
    checkOutput("accepts_en_low", 32'(n_accept - acc0), 32'd1);
    en = 1'b1;
    expectPacket(3, 32'h0000_0200, 1'b0);
    waitDrain(200);
    exp_pkt = 8;
    checkOutput("pkt_cnt_en_high", pkt_cnt, 32'(exp_pkt));

    $display("[TB] reset during load");
    applyStimulus(8, 32'h0000_0300, 1'b0);
    waitEvent(1, n_writes + 3, 200);
    #3 rst_n = 1'b0;
    #1;
    checkOutput("arst_wren", 32'(bus.rdout_dpram_wren), 32'd0);
    checkOutput("arst_addr", 32'(bus.rdout_dpram_wr_addr), 32'd0);
    checkOutput("arst_data", bus.rdout_dpram_data, 32'd0);
    checkOutput("arst_data_rdreq", 32'(bus.data_rdreq), 32'd0);
    checkOutput("arst_pkt_cnt", pkt_cnt, 32'd0);
    hq.delete();
    dq.delete();
    sb.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(2, 32'h0000_0400, 1'b1);
    waitDrain(200);
    exp_pkt = 1;
    checkOutput("pkt_cnt_after_reset", pkt_cnt, 32'(exp_pkt));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
